// File: rtl/clk_cnt_rd_pkg.sv
// Shared types and address helpers for the cycle-counter read port.
package clk_cnt_rd_pkg;

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    localparam int DATA_W_DEF = 16;

    function automatic int nwords(input int dw);
        return 64 / dw;
    endfunction

    function automatic int addr_w(input int dw);
        return $clog2(2 * (64 / dw));
    endfunction

    localparam int ADDR_SNAP0  = 0;
    localparam int ADDR_DELTA0 = nwords(DATA_W_DEF);

endpackage

// File: rtl/clk_cnt_snap.sv
// Snapshot/delta registers and the word mux over both 64-bit values.
module clk_cnt_snap
    import clk_cnt_rd_pkg::*;
#(
    parameter  int DATA_W = 16,
    localparam int NWORDS = nwords(DATA_W),
    localparam int ADDR_W = addr_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       clk_cnt,
    input  logic              capture,
    input  logic              clear,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] word
);

    logic [63:0]  snap;
    logic [63:0]  delta;
    logic [127:0] both;
    logic [6:0]   off;

    // Capture outranks clear when both land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap  <= '0;
            delta <= '0;
        end else if (capture) begin
            snap  <= clk_cnt;
            delta <= clk_cnt - snap;
        end else if (clear) begin
            snap  <= '0;
            delta <= '0;
        end
    end

    // Snapshot occupies the low words, delta the high words.
    assign both = {delta, snap};
    assign off  = 7'(addr) * 7'(DATA_W);
    assign word = both[off +: DATA_W];

endmodule

// File: rtl/clk_cnt_reader.sv
// Request/valid/ack read port returning snapshot and delta words
// of the free-running cycle counter.
module clk_cnt_reader
    import clk_cnt_rd_pkg::*;
#(
    parameter  int DATA_W = 16,
    localparam int NWORDS = nwords(DATA_W),
    localparam int ADDR_W = addr_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       clk_cnt,
    input  logic              lap_clr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ack
);

    state_e            state;
    logic              accept;
    logic              capture;
    logic [DATA_W-1:0] word;

    assign accept  = rd_req && rd_ready;
    assign capture = accept && (rd_addr == ADDR_W'(ADDR_SNAP0));

    clk_cnt_snap #(
        .DATA_W (DATA_W)
    ) u_snap (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_cnt (clk_cnt),
        .capture (capture),
        .clear   (lap_clr),
        .addr    (rd_addr),
        .word    (word)
    );

    // Word 0 comes straight from the live count so it matches the new snap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_ready <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= RESP;
                        rd_ready <= 1'b0;
                        rd_valid <= 1'b1;
                        rd_data  <= capture ? clk_cnt[DATA_W-1:0] : word;
                    end
                end
                RESP: begin
                    if (rd_ack) begin
                        state    <= IDLE;
                        rd_ready <= 1'b1;
                        rd_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    rd_ready <= 1'b1;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_cnt_reader.sv
// Randomised and directed checks of clk_cnt_reader against a
// transaction-level model of snapshot, delta and the read handshake.
module tb_clk_cnt_reader;

    localparam int DW = 16;
    localparam int NW = 64 / DW;
    localparam int AW = $clog2(2 * NW);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   clk_cnt;
    logic          lap_clr;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ack;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    logic [63:0] cnt_step = 64'd1;

    logic          m_busy;
    logic [DW-1:0] m_data;
    logic [63:0]   m_snap;
    logic [63:0]   m_delta;

    clk_cnt_reader #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_cnt  (clk_cnt),
        .lap_clr  (lap_clr),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ack   (rd_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mword(input logic [63:0] v, input int i);
        return DW'(v >> (DW * i));
    endfunction

    // Transaction model: one outstanding read, snapshot/delta as 64-bit values.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_data  <= '0;
            m_snap  <= '0;
            m_delta <= '0;
        end else if (!m_busy && rd_req) begin
            m_busy <= 1'b1;
            if (int'(rd_addr) == 0) begin
                m_data  <= clk_cnt[DW-1:0];
                m_snap  <= clk_cnt;
                m_delta <= clk_cnt - m_snap;
            end else begin
                if (int'(rd_addr) < NW)
                    m_data <= mword(m_snap, int'(rd_addr));
                else
                    m_data <= mword(m_delta, int'(rd_addr) - NW);
                if (lap_clr) begin
                    m_snap  <= '0;
                    m_delta <= '0;
                end
            end
        end else begin
            if (m_busy && rd_ack) m_busy <= 1'b0;
            if (lap_clr) begin
                m_snap  <= '0;
                m_delta <= '0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp <= n_cmp + 3;
            if (rd_ready !== !m_busy || rd_valid !== m_busy || rd_data !== m_data) begin
                n_bad <= n_bad + 1;
                $display("FAIL model t=%0t rdy=%b/%b vld=%b/%b data=%h/%h",
                         $time, rd_ready, !m_busy, rd_valid, m_busy,
                         rd_data, m_data);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clk_cnt = clk_cnt + cnt_step;
    endtask

    task automatic rd(input int addr, input bit lc, input int dly,
                      output logic [DW-1:0] data);
        int guard = 0;
        while (!rd_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!rd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout addr=%0d", addr);
        end
        rd_req  = 1'b1;
        rd_addr = AW'(addr);
        lap_clr = lc;
        tick();
        rd_req  = 1'b0;
        lap_clr = 1'b0;
        data    = rd_data;
        for (int k = 0; k < dly; k++) begin
            rd_req  = 1'($urandom_range(0, 1));
            rd_addr = AW'($urandom_range(0, 2 * NW - 1));
            tick();
        end
        rd_req = 1'b0;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] held;
        rst_n   = 1'b0;
        clk_cnt = '0;
        lap_clr = 1'b0;
        rd_req  = 1'b0;
        rd_addr = '0;
        rd_ack  = 1'b0;
        tick();
        tick();
        check("reset_ready", 64'(rd_ready), 64'd1);
        check("reset_valid", 64'(rd_valid), 64'd0);
        check("reset_data", 64'(rd_data), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        cnt_step = 64'd1;
        clk_cnt  = 64'h0000_0000_0001_2345;
        rd_req   = 1'b1;
        rd_addr  = '0;
        tick();
        rd_req = 1'b0;
        check("mid_resp_valid", 64'(rd_valid), 64'd1);
        check("mid_resp_data", 64'(rd_data), 64'h2345);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(rd_valid), 64'd0);
        check("rst_mid_ready", 64'(rd_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        rd(1, 1'b0, 0, d);
        check("rst_mid_addr1", 64'(d), 64'd0);

        clk_cnt = 64'h1122_3344_5566_7788;
        rd(0, 1'b0, 0, d);
        check("coh_w0", 64'(d), 64'h7788);
        rd(1, 1'b0, 1, d);
        check("coh_w1", 64'(d), 64'h5566);
        rd(2, 1'b0, 0, d);
        check("coh_w2", 64'(d), 64'h3344);
        rd(3, 1'b0, 2, d);
        check("coh_w3", 64'(d), 64'h1122);

        clk_cnt = 64'hFFFF_FFFF_FFFF_FFF0;
        rd(0, 1'b0, 0, d);
        clk_cnt = 64'h0000_0000_0000_0010;
        rd(0, 1'b0, 0, d);
        check("wrap_w0", 64'(d), 64'h0010);
        for (int a = 4; a < 8; a++) begin
            rd(a, 1'b0, 0, d);
            check("wrap_delta", 64'(d), (a == 4) ? 64'h20 : 64'h0);
        end

        rd_req  = 1'b1;
        rd_addr = AW'(2);
        tick();
        held = rd_data;
        for (int k = 0; k < 10; k++) begin
            rd_req  = 1'(k % 2);
            rd_addr = '0;
            tick();
            check("stall_valid", 64'(rd_valid), 64'd1);
            check("stall_ready", 64'(rd_ready), 64'd0);
            check("stall_data", 64'(rd_data), 64'(held));
        end
        rd_req = 1'b0;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check("stall_release", 64'(rd_ready), 64'd1);

        cnt_step = 64'd0;
        clk_cnt  = 64'd100;
        rd(0, 1'b0, 0, d);
        clk_cnt = 64'd500;
        rd(0, 1'b1, 0, d);
        check("lap_snap0", 64'(d), 64'd500);
        rd(1, 1'b0, 0, d);
        check("lap_snap1", 64'(d), 64'd0);
        rd(4, 1'b0, 0, d);
        check("lap_delta", 64'(d), 64'd400);
        lap_clr = 1'b1;
        tick();
        lap_clr = 1'b0;
        for (int a = 1; a < 8; a++) begin
            rd(a, 1'b0, 0, d);
            check("lap_cleared", 64'(d), 64'd0);
        end
        rd(0, 1'b0, 0, d);
        check("lap_recap", 64'(d), 64'd500);
        rd(4, 1'b0, 0, d);
        check("lap_first_delta", 64'(d), 64'd500);

        clk_cnt = 64'd42;
        rd(0, 1'b0, 0, d);
        rd(0, 1'b0, 0, d);
        check("halt_snap", 64'(d), 64'd42);
        rd(4, 1'b0, 0, d);
        check("halt_delta", 64'(d), 64'd0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                clk_cnt  = {$urandom, $urandom};
                cnt_step = 64'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) begin
                lap_clr = 1'b1;
                tick();
                lap_clr = 1'b0;
            end
            rd($urandom_range(0, 2 * NW - 1), 1'($urandom_range(0, 5) == 0),
               $urandom_range(0, 3), d);
        end

        chk_en = 1'b0;
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
